// File: rtl/option_fifo_feeder_if.sv
// Solver-facing option stream: show-ahead pop port plus the put-back return path.
interface option_fifo_feeder_if #(
  parameter int unsigned OPT_W = 16
);
  logic             read_req;
  logic [OPT_W-1:0] option_out;
  logic             option_valid;
  logic             is_index;
  logic             putback_valid;
  logic [OPT_W-1:0] putback_option;

  modport master (
    input  read_req, putback_valid, putback_option,
    output option_out, option_valid, is_index
  );

  modport slave (
    output read_req, putback_valid, putback_option,
    input  option_out, option_valid, is_index
  );
endinterface

// File: rtl/option_fifo_feeder.sv
// Per-axis option store: streams each line as an index word plus its options,
// and recirculates the options the solver keeps for the next round.
module option_fifo_feeder #(
  parameter int unsigned OPT_W     = 16,
  parameter int unsigned MAX_LINES = 11,
  parameter int unsigned LINE_W    = 4,
  parameter int unsigned CNT_W     = 7,
  parameter int unsigned DEPTH     = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LINE_W-1:0]            num_lines,
  input  logic                         load_valid,
  input  logic [LINE_W-1:0]            load_line,
  input  logic [OPT_W-1:0]             load_option,
  input  logic                         load_done,
  input  logic                         start_round,
  option_fifo_feeder_if.master         stream,
  output logic [MAX_LINES*CNT_W-1:0]   options_amnt,
  output logic                         round_done,
  output logic                         busy,
  output logic                         overflow
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;
  localparam int unsigned LW1   = LINE_W + 1;

  typedef enum logic [2:0] {IDLE, READY, SEND_IDX, SEND_OPT, DONE} state_t;

  state_t                             state, state_nxt;
  logic [LINE_W-1:0]                  line, line_nxt, prev_line, prev_line_nxt, num_q, num_q_nxt;
  logic [CNT_W-1:0]                   remaining, remaining_nxt, new_cnt, new_cnt_nxt;
  logic [MAX_LINES-1:0][CNT_W-1:0]    amnt, amnt_nxt;
  logic [PTR_W-1:0]                   rd_ptr, rd_ptr_nxt, wr_ptr, wr_ptr_nxt;
  logic [CW-1:0]                      count, count_nxt;
  logic [OPT_W-1:0]                   out_q, out_nxt;
  logic                               valid_q, valid_nxt, idx_q, idx_nxt;
  logic                               pb_window, pb_window_nxt;
  logic                               round_done_nxt, busy_nxt, overflow_nxt;
  logic [OPT_W-1:0]                   mem [DEPTH];

  logic             full, pop, ld_try, pb_try, pb_ok, wr_en;
  logic [LW1-1:0]   first_hit, next_hit;
  logic [OPT_W-1:0] head, head_next;

  // Lowest line in [from, lim) that still owns options; MSB flags a hit.
  function automatic logic [LW1-1:0] find_line(input logic [LW1-1:0] from,
                                               input logic [LINE_W-1:0] lim,
                                               input logic [MAX_LINES-1:0][CNT_W-1:0] a);
    logic [LW1-1:0] r;
    r = '0;
    for (int i = int'(MAX_LINES) - 1; i >= 0; i--) begin
      if (i >= int'(from) && i < int'(lim) && a[i] != '0) r = {1'b1, LINE_W'(i)};
    end
    return r;
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign pop       = (state == SEND_OPT) && valid_q && stream.read_req;
  assign ld_try    = (state == IDLE) && load_valid && (int'(load_line) < int'(MAX_LINES));
  assign pb_try    = stream.putback_valid && ((state == SEND_OPT) || pb_window);
  assign pb_ok     = pb_try && (!full || pop);
  assign wr_en     = (ld_try || pb_try) && (!full || pop);
  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + PTR_W'(1)];
  assign first_hit = find_line('0, num_lines, amnt);
  assign next_hit  = find_line({1'b0, line} + LW1'(1), num_q, amnt);

  // Next-state, pointer/count and registered-output logic
  always_comb begin
    state_nxt      = state;
    line_nxt       = line;
    prev_line_nxt  = prev_line;
    num_q_nxt      = num_q;
    remaining_nxt  = remaining;
    new_cnt_nxt    = new_cnt;
    amnt_nxt       = amnt;
    out_nxt        = out_q;
    valid_nxt      = valid_q;
    idx_nxt        = idx_q;
    pb_window_nxt  = 1'b0;
    overflow_nxt   = overflow || ((ld_try || pb_try) && !wr_en);
    rd_ptr_nxt     = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    wr_ptr_nxt     = wr_en ? wr_ptr + PTR_W'(1) : wr_ptr;
    count_nxt      = count + CW'(wr_en) - CW'(pop);

    case (state)
      IDLE: begin
        if (ld_try && wr_en) amnt_nxt[load_line] = amnt[load_line] + CNT_W'(1);
        if (load_done) state_nxt = READY;
      end
      READY: begin
        if (start_round && count != '0) begin
          num_q_nxt = num_lines;
          if (first_hit[LINE_W]) begin
            state_nxt = SEND_IDX;
            line_nxt  = first_hit[LINE_W-1:0];
          end else begin
            state_nxt = DONE;
          end
        end
      end
      SEND_IDX: begin
        // Index word is presented one cycle after entry, leaving a gap between lines.
        if (!valid_q) begin
          out_nxt   = OPT_W'(line);
          valid_nxt = 1'b1;
          idx_nxt   = 1'b1;
        end else if (stream.read_req) begin
          state_nxt     = SEND_OPT;
          remaining_nxt = amnt[line];
          new_cnt_nxt   = '0;
          out_nxt       = head;
          idx_nxt       = 1'b0;
        end
      end
      SEND_OPT: begin
        if (pop) begin
          remaining_nxt = remaining - CNT_W'(1);
          new_cnt_nxt   = new_cnt + CNT_W'(pb_ok);
          if (remaining == CNT_W'(1)) begin
            amnt_nxt[line] = new_cnt + CNT_W'(pb_ok);
            prev_line_nxt  = line;
            pb_window_nxt  = 1'b1;
            valid_nxt      = 1'b0;
            idx_nxt        = 1'b0;
            if (next_hit[LINE_W]) begin
              state_nxt = SEND_IDX;
              line_nxt  = next_hit[LINE_W-1:0];
            end else begin
              state_nxt = DONE;
            end
          end else begin
            out_nxt = head_next;
          end
        end else if (pb_ok) begin
          new_cnt_nxt = new_cnt + CNT_W'(1);
        end
      end
      DONE: state_nxt = READY;
      default: state_nxt = IDLE;
    endcase

    // Late put-back for a line whose final pop happened last cycle
    if (pb_window && pb_ok) amnt_nxt[prev_line] = amnt[prev_line] + CNT_W'(1);

    round_done_nxt = (state_nxt == DONE);
    busy_nxt       = (state_nxt != IDLE) && (state_nxt != READY);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      line       <= '0;
      prev_line  <= '0;
      num_q      <= '0;
      remaining  <= '0;
      new_cnt    <= '0;
      amnt       <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      idx_q      <= 1'b0;
      pb_window  <= 1'b0;
      round_done <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      line       <= line_nxt;
      prev_line  <= prev_line_nxt;
      num_q      <= num_q_nxt;
      remaining  <= remaining_nxt;
      new_cnt    <= new_cnt_nxt;
      amnt       <= amnt_nxt;
      rd_ptr     <= rd_ptr_nxt;
      wr_ptr     <= wr_ptr_nxt;
      count      <= count_nxt;
      out_q      <= out_nxt;
      valid_q    <= valid_nxt;
      idx_q      <= idx_nxt;
      pb_window  <= pb_window_nxt;
      round_done <= round_done_nxt;
      busy       <= busy_nxt;
      overflow   <= overflow_nxt;
    end
  end

  // Option storage; contents are meaningless after reset since pointers restart.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= ld_try ? load_option : stream.putback_option;
  end

  assign stream.option_out   = out_q;
  assign stream.option_valid = valid_q;
  assign stream.is_index     = idx_q;
  assign options_amnt        = amnt;
endmodule

// File: tb/tb_option_fifo_feeder.sv
// Directed bench: a DEPTH=256 instance for streaming/put-back rounds and a DEPTH=4
// instance for overflow and pointer wrap; both share stimulus, sel picks the observed one.
module tb_option_fifo_feeder;
  localparam int unsigned OPT_W = 16, MAX_LINES = 11, LINE_W = 4, CNT_W = 7;
  localparam int unsigned AW = MAX_LINES * CNT_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sel = 1'b0;
  logic [LINE_W-1:0] num_lines = '0, load_line = '0;
  logic              load_valid = 1'b0, load_done = 1'b0, start_round = 1'b0;
  logic [OPT_W-1:0]  load_option = '0, putback_option = '0;
  logic              read_req = 1'b0, putback_valid = 1'b0;

  logic [AW-1:0] b_amnt, s_amnt, amnt;
  logic b_done, s_done, b_busy, s_busy, b_ovf, s_ovf;
  logic rdone, busy, ovf, valid, isidx;
  logic [OPT_W-1:0] opt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  option_fifo_feeder_if #(.OPT_W(OPT_W)) bif ();
  option_fifo_feeder_if #(.OPT_W(OPT_W)) sif ();

  assign bif.read_req = read_req;           assign sif.read_req = read_req;
  assign bif.putback_valid = putback_valid; assign sif.putback_valid = putback_valid;
  assign bif.putback_option = putback_option; assign sif.putback_option = putback_option;

  option_fifo_feeder #(.DEPTH(256)) u_big (
    .clk(clk), .rst(rst), .num_lines(num_lines), .load_valid(load_valid),
    .load_line(load_line), .load_option(load_option), .load_done(load_done),
    .start_round(start_round), .stream(bif.master), .options_amnt(b_amnt),
    .round_done(b_done), .busy(b_busy), .overflow(b_ovf));

  option_fifo_feeder #(.DEPTH(4)) u_small (
    .clk(clk), .rst(rst), .num_lines(num_lines), .load_valid(load_valid),
    .load_line(load_line), .load_option(load_option), .load_done(load_done),
    .start_round(start_round), .stream(sif.master), .options_amnt(s_amnt),
    .round_done(s_done), .busy(s_busy), .overflow(s_ovf));

  assign opt   = sel ? sif.option_out   : bif.option_out;
  assign valid = sel ? sif.option_valid : bif.option_valid;
  assign isidx = sel ? sif.is_index     : bif.is_index;
  assign amnt  = sel ? s_amnt : b_amnt;
  assign rdone = sel ? s_done : b_done;
  assign busy  = sel ? s_busy : b_busy;
  assign ovf   = sel ? s_ovf  : b_ovf;

  task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    logic [AW-1:0] r;
    r = '0;
    r[0*CNT_W +: CNT_W] = CNT_W'(a0);
    r[1*CNT_W +: CNT_W] = CNT_W'(a1);
    r[2*CNT_W +: CNT_W] = CNT_W'(a2);
    r[3*CNT_W +: CNT_W] = CNT_W'(a3);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    load_valid = 1'b0; load_done = 1'b0; start_round = 1'b0;
    read_req = 1'b0; putback_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic load(input int l, input int o);
    load_valid = 1'b1; load_line = LINE_W'(l); load_option = OPT_W'(o);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic finish_load();
    load_done = 1'b1; tick(); load_done = 1'b0;
  endtask

  task automatic start(input int n);
    num_lines = LINE_W'(n); start_round = 1'b1; tick(); start_round = 1'b0;
  endtask

  // Wait for the head word, compare it, then pop it (optionally putting it back).
  task automatic pop(input string tag, input logic exp_idx, input int exp_val, input logic pb);
    int n;
    n = 0;
    while (!valid && n < 20) begin tick(); n++; end
    check({tag, "_valid"}, AW'(valid), AW'(1));
    check({tag, "_isidx"}, AW'(isidx), AW'(exp_idx));
    check({tag, "_word"}, AW'(opt), AW'(exp_val));
    read_req = 1'b1; putback_valid = pb; putback_option = OPT_W'(exp_val);
    tick();
    read_req = 1'b0; putback_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!rdone && n < 20) begin tick(); n++; end
    check({tag, "_round_done"}, AW'(rdone), AW'(1));
    tick();
  endtask

  initial begin
    // Reset values
    #2;
    check("rst_out", AW'(opt), AW'(0));
    check("rst_valid", AW'(valid), AW'(0));
    check("rst_isidx", AW'(isidx), AW'(0));
    check("rst_done", AW'(rdone), AW'(0));
    check("rst_ovf", AW'(ovf), AW'(0));
    check("rst_amnt", amnt, AW'(0));
    do_reset();

    // 4x4 board load: rows 0..3 with 3,3,3,1 options
    load(0, 'b0011); load(0, 'b0110); load(0, 'b1100);
    load(1, 'b0011); load(1, 'b1001); load(1, 'b0110);
    load(2, 'b1001); load(2, 'b0101); load(2, 'b1010);
    load(3, 'b1101);
    check("load_amnt", amnt, pack4(3, 3, 3, 1));
    start(0);
    check("start_in_idle", AW'(busy), AW'(0));
    finish_load();
    start(4);
    check("busy_round", AW'(busy), AW'(1));

    // Round 1 with put-backs
    pop("r1_idx0", 1'b1, 0, 1'b0);
    pop("r1_r0a", 1'b0, 'b0011, 1'b1);
    pop("r1_r0b", 1'b0, 'b0110, 1'b1);
    pop("r1_r0c", 1'b0, 'b1100, 1'b1);
    check("r1_gap", AW'(valid), AW'(0));
    pop("r1_idx1", 1'b1, 1, 1'b0);
    pop("r1_r1a", 1'b0, 'b0011, 1'b1);
    check("r1_mid_amnt", amnt, pack4(3, 3, 3, 1));
    pop("r1_r1b", 1'b0, 'b1001, 1'b0);
    pop("r1_r1c", 1'b0, 'b0110, 1'b0);
    pop("r1_idx2", 1'b1, 2, 1'b0);
    pop("r1_r2a", 1'b0, 'b1001, 1'b1);
    pop("r1_r2b", 1'b0, 'b0101, 1'b1);
    pop("r1_r2c", 1'b0, 'b1010, 1'b0);
    pop("r1_idx3", 1'b1, 3, 1'b0);
    pop("r1_r3a", 1'b0, 'b1101, 1'b0);
    check("r1_round_done", AW'(rdone), AW'(1));
    check("r1_done_valid", AW'(valid), AW'(0));
    putback_valid = 1'b1; putback_option = OPT_W'('b1101);
    tick();
    putback_valid = 1'b0;
    check("r1_done_pulse", AW'(rdone), AW'(0));
    check("r1_amnt", amnt, pack4(3, 1, 2, 1));
    check("r1_idle_busy", AW'(busy), AW'(0));

    // Round 2: row 1 keeps nothing
    start(4);
    pop("r2_idx0", 1'b1, 0, 1'b0);
    pop("r2_r0a", 1'b0, 'b0011, 1'b1);
    pop("r2_r0b", 1'b0, 'b0110, 1'b1);
    pop("r2_r0c", 1'b0, 'b1100, 1'b1);
    pop("r2_idx1", 1'b1, 1, 1'b0);
    pop("r2_r1a", 1'b0, 'b0011, 1'b0);
    pop("r2_idx2", 1'b1, 2, 1'b0);
    pop("r2_r2a", 1'b0, 'b1001, 1'b1);
    pop("r2_r2b", 1'b0, 'b0101, 1'b1);
    pop("r2_idx3", 1'b1, 3, 1'b0);
    pop("r2_r3a", 1'b0, 'b1101, 1'b1);
    wait_done("r2");
    check("r2_amnt", amnt, pack4(3, 0, 2, 1));

    // Round 3: empty row 1 is skipped
    start(4);
    pop("r3_idx0", 1'b1, 0, 1'b0);
    pop("r3_r0a", 1'b0, 'b0011, 1'b0);
    pop("r3_r0b", 1'b0, 'b0110, 1'b0);
    pop("r3_r0c", 1'b0, 'b1100, 1'b0);
    pop("r3_idx2", 1'b1, 2, 1'b0);

    // DEPTH=4: overflow on put-back without pop, none with simultaneous pop
    sel = 1'b1;
    do_reset();
    load(0, 'hA1); load(0, 'hB2); load(0, 'hC3); load(0, 'hD4);
    finish_load();
    start(1);
    pop("ov_idx0", 1'b1, 0, 1'b0);
    pop("ov_a", 1'b0, 'hA1, 1'b1);
    check("ov_pop_pb_full", AW'(ovf), AW'(0));
    putback_valid = 1'b1; putback_option = OPT_W'('hEE);
    tick();
    putback_valid = 1'b0;
    check("ov_flag", AW'(ovf), AW'(1));
    pop("ov_b", 1'b0, 'hB2, 1'b0);
    pop("ov_c", 1'b0, 'hC3, 1'b0);
    pop("ov_d", 1'b0, 'hD4, 1'b0);
    wait_done("ov");
    check("ov_amnt", amnt, pack4(1, 0, 0, 0));
    check("ov_sticky", AW'(ovf), AW'(1));
    start(1);
    pop("ov2_idx0", 1'b1, 0, 1'b0);
    pop("ov2_a", 1'b0, 'hA1, 1'b0);
    wait_done("ov2");
    check("ov2_amnt", amnt, AW'(0));

    // DEPTH=4 wrap-around over three full recirculations
    do_reset();
    check("wrap_ovf_clear", AW'(ovf), AW'(0));
    load(0, 'h11); load(0, 'h22); load(0, 'h33);
    finish_load();
    for (int r = 0; r < 3; r++) begin
      start(1);
      pop("wr_idx0", 1'b1, 0, 1'b0);
      pop("wr_a", 1'b0, 'h11, 1'b1);
      pop("wr_b", 1'b0, 'h22, 1'b1);
      pop("wr_c", 1'b0, 'h33, 1'b1);
      wait_done("wr");
      check("wr_amnt", amnt, pack4(3, 0, 0, 0));
    end

    // Asynchronous reset in the middle of a line
    start(1);
    pop("mr_idx0", 1'b1, 0, 1'b0);
    pop("mr_a", 1'b0, 'h11, 1'b1);
    check("mr_pre_valid", AW'(valid), AW'(1));
    rst = 1'b0;
    #1;
    check("mr_out", AW'(opt), AW'(0));
    check("mr_valid", AW'(valid), AW'(0));
    check("mr_isidx", AW'(isidx), AW'(0));
    check("mr_busy", AW'(busy), AW'(0));
    check("mr_amnt", amnt, AW'(0));
    tick();
    rst = 1'b1;
    tick();
    start(1);
    tick();
    check("mr_start_ignored_valid", AW'(valid), AW'(0));
    check("mr_start_ignored_busy", AW'(busy), AW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/option_fifo_feeder.md
Name: option_fifo_feeder

Overview:
- Producer side of the solver's option-stream interface: stores every candidate option for one axis (rows or columns) and streams them to parrallel_solver line by line.
- Each line's segment is a generated line-index word followed by that line's options. The solver consumes with read_from_fifo.
- Options the solver keeps are returned via put_back_to_FIFO. The block appends them to the tail and counts them per line, which yields old_options_amnt for the next round.
- One instance per axis, between the option generator and the solver.

Parameters:
OPT_W, 16, option/index word width
MAX_LINES, 11, max lines per axis
LINE_W, 4, line-index width
CNT_W, 7, per-line option count width
DEPTH, 256, option storage entries (power of two)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low (asserted at 0)
num_lines  in  LINE_W  lines on this axis; sampled at start_round
load_valid  in  1  append load_option for line load_line (LOAD phase only)
load_line  in  LINE_W  line owning load_option; nondecreasing during load
load_option  in  OPT_W  generated option
load_done  in  1  end of initial load; IDLE -> ready
start_round  in  1  begin streaming one full round
read_req  in  1  solver pop (read_from_fifo)
option_out  out  OPT_W  head word (index or option)
option_valid  out  1  option_out valid
is_index  out  1  option_out is a line-index word
putback_valid  in  1  solver keeps option (put_back_to_FIFO)
putback_option  in  OPT_W  returned option (new_option)
options_amnt  out  MAX_LINES*CNT_W  per-line option count (old_options_amnt)
round_done  out  1  one-cycle pulse after last line of a round
busy  out  1  state != IDLE/READY
overflow  out  1  sticky: write attempted while full

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; pointers, count and options_amnt all zero.
  - option_out=0; option_valid, is_index, round_done and overflow low.
- Storage: circular buffer with wr_ptr, rd_ptr, count. Pointers wrap modulo DEPTH. Full: count==DEPTH. Empty: count==0.
- States:
  - IDLE: load_valid writes the option and increments options_amnt[load_line]. load_done -> READY.
  - READY: start_round with count>0 -> SEND_IDX, line=first line with nonzero amnt. Otherwise stays READY.
  - SEND_IDX: option_out={zero-extended line}, is_index=1, option_valid=1. read_req -> SEND_OPT; remaining=options_amnt[line]; new_cnt=0.
  - SEND_OPT: option_out=buffer[rd_ptr], is_index=0. Each read_req pops (rd_ptr++, remaining--). The pop taking remaining to 0 ends the line:
    - options_amnt[line]<=new_cnt, including a putback in the same cycle.
    - Advance to the next line <num_lines with nonzero amnt and go to SEND_IDX, or to DONE if none.
  - DONE: round_done=1 for one cycle -> READY.
- Show-ahead output: option_out/option_valid are registered and reflect the head. After a pop the next word is valid the following cycle. option_valid drops for one cycle between lines (the index word is issued the cycle after the last option pop).
- read_req while option_valid=0 is ignored.
- Putback:
  - Legal in SEND_OPT, or in the cycle after the line's last pop.
  - Writes at wr_ptr and increments new_cnt for the line being read. Options returned for line L are stored behind all not-yet-read data, so they stream in the next round.
  - Pop and putback in the same cycle: count unchanged, both pointers advance.
  - Putback when full and no simultaneous pop: dropped, overflow=1 (sticky until reset).
  - Putback outside the legal window: ignored.
- Line with options_amnt=0 (contradiction or empty): skipped entirely, no index word.
- options_amnt updates only at line end. Mid-line reads of the output show the old value.
- start_round outside READY: ignored. load_valid outside IDLE: ignored.
- Reset mid-round: all state cleared, buffer contents discarded; the generator must reload.

Test Plan:
- Load rows 0..3 with amounts 3,3,3,1 (row 0: 0011,0110,1100), then start_round.
  - Stream is idx 0000, 0011, 0110, 1100, then idx 0001.
  - is_index high only on index words.
- Round 1 on the 4x4 board with putbacks:
  - Row 0: put back 0011,0110,1100. Row 1: put back 0011 only. Row 2: put back 1001,0101. Row 3: put back 1101.
  - After round_done: options_amnt = 3,1,2,1.
  - Round 2 streams row 1 as idx 0001, 0011.
- Line with zero putbacks (row 1 amount 0 next round): row 1 skipped; stream goes idx 0000 ... last option, then idx 0010.
- DEPTH=4 bench: load 4 options, then force a putback with no pop → overflow=1 and the option is dropped. Simultaneous pop+putback at full → no overflow.
- Wrap-around, DEPTH=4, 3 rounds of 3 options each fully put back: option order is preserved each round, and pointers wrap without corrupting data.
- Assert rst low mid SEND_OPT: all outputs return to reset values immediately. start_round after reset is ignored until load_done.
